// File: rtl/nasti_stream_reader.sv
// Memory-to-stream mover: fetches r_len beats over NASTI AR/R in INCR bursts and emits them as one stream packet.
// Optional macro NASTI_STREAM_READER_RESP_CHECK_EN: non-OKAY R beats set the sticky err flag and zero that beat's t_strb.
module nasti_stream_reader #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // Every handshake below transfers on a rising aclk edge where valid and ready are both high;
    // a raised valid keeps its payload stable until that edge.
    output logic                    src_ar_valid,
    input  logic                    src_ar_ready,
    output logic [3:0]              src_ar_id,
    output logic [ADDR_WIDTH-1:0]   src_ar_addr,
    output logic [7:0]              src_ar_len,
    output logic [2:0]              src_ar_size,
    output logic [1:0]              src_ar_burst,
    output logic                    src_ar_lock,
    output logic [3:0]              src_ar_cache,
    output logic [2:0]              src_ar_prot,
    input  logic                    src_r_valid,
    output logic                    src_r_ready,
    input  logic [DATA_WIDTH-1:0]   src_r_data,
    input  logic [1:0]              src_r_resp,
    input  logic                    src_r_last,
    output logic                    src_aw_valid,
    output logic                    src_w_valid,
    output logic                    src_b_ready,
    output logic                    dest_t_valid,
    input  logic                    dest_t_ready,
    output logic [DATA_WIDTH-1:0]   dest_t_data,
    output logic [DATA_WIDTH/8-1:0] dest_t_keep,
    output logic [DATA_WIDTH/8-1:0] dest_t_strb,
    output logic                    dest_t_last,
    input  logic [ADDR_WIDTH-1:0]   r_src,
    input  logic [LEN_WIDTH-1:0]    r_len,
    input  logic                    r_valid,
    output logic                    r_ready,
    output logic                    err,
    output logic [1:0]              dbg_req_state,
    output logic [1:0]              dbg_ar_state
);
    localparam int ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int DEPTH      = 2 * MAX_BURST_LENGTH;
    localparam int IW         = $clog2(DEPTH);
    localparam int PW         = IW + 1;
    localparam int OW         = $clog2(MAX_BURST_LENGTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((64'd1 << ADDR_SHIFT) - 64'd1);
    localparam logic [LEN_WIDTH-1:0]  MAX_BLEN  = LEN_WIDTH'(MAX_BURST_LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO} req_state_t;
    typedef enum logic [1:0] {AR_IDLE, AR_ADDR, AR_DATA} ar_state_t;

    req_state_t            req_state, req_next;
    ar_state_t             ar_state, ar_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  ar_rem, out_rem, blen;
    logic [OW-1:0]         outstanding;
    logic [PW-1:0]         wr_ptr, rd_ptr, used, free_slots;
    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic                  accept, ar_fire, r_fire, pop, fifo_empty, free_ok, head_bad;

    assign accept     = r_valid && r_ready;
    assign ar_fire    = src_ar_valid && src_ar_ready;
    assign r_fire     = src_r_valid && src_r_ready;
    assign pop        = dest_t_valid && dest_t_ready && (req_state == S_RUN);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign used       = wr_ptr - rd_ptr;
    assign free_slots = PW'(DEPTH) - used;
    assign blen       = (ar_rem > MAX_BLEN) ? MAX_BLEN : ar_rem;
    // A burst is only requested when the whole of it fits, so R never needs back-pressure.
    assign free_ok    = (LEN_WIDTH'(free_slots) >= blen);

    assign src_ar_id    = 4'd0;
    assign src_ar_addr  = addr;
    assign src_ar_len   = 8'(blen - LEN_WIDTH'(1));
    assign src_ar_size  = 3'(ADDR_SHIFT);
    assign src_ar_burst = 2'b01;
    assign src_ar_lock  = 1'b0;
    assign src_ar_cache = 4'd0;
    assign src_ar_prot  = 3'd0;
    assign src_aw_valid = 1'b0;
    assign src_w_valid  = 1'b0;
    assign src_b_ready  = 1'b1;
    assign dest_t_data  = fifo_data[rd_ptr[IW-1:0]];
    assign dbg_req_state = req_state;
    assign dbg_ar_state  = ar_state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_state <= S_IDLE;
            ar_state  <= AR_IDLE;
        end else begin
            req_state <= req_next;
            ar_state  <= ar_next;
        end
    end

    always_comb begin
        req_next = req_state;
        case (req_state)
            S_IDLE:  if (r_valid) req_next = (r_len == '0) ? S_ZERO : S_RUN;
            S_RUN:   if (pop && out_rem == LEN_WIDTH'(1)) req_next = S_IDLE;
            S_ZERO:  if (dest_t_ready) req_next = S_IDLE;
            default: req_next = S_IDLE;
        endcase
        ar_next = ar_state;
        case (ar_state)
            AR_IDLE: if (ar_rem != '0 && free_ok) ar_next = AR_ADDR;
            AR_ADDR: if (src_ar_ready) ar_next = AR_DATA;
            AR_DATA: if (r_fire && src_r_last) ar_next = AR_IDLE;
            default: ar_next = AR_IDLE;
        endcase
    end

    always_comb begin
        r_ready      = (req_state == S_IDLE);
        src_ar_valid = (ar_state == AR_ADDR);
        src_r_ready  = (ar_state == AR_DATA);
        dest_t_valid = 1'b0;
        dest_t_last  = 1'b0;
        dest_t_keep  = '0;
        dest_t_strb  = '0;
        case (req_state)
            S_RUN: begin
                dest_t_valid = !fifo_empty;
                dest_t_last  = !fifo_empty && (out_rem == LEN_WIDTH'(1));
                dest_t_keep  = '1;
                dest_t_strb  = head_bad ? '0 : '1;
            end
            S_ZERO: begin
                dest_t_valid = 1'b1;
                dest_t_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr        <= '0;
            ar_rem      <= '0;
            out_rem     <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (accept) begin
                addr    <= r_src & ~ADDR_MASK;
                ar_rem  <= r_len;
                out_rem <= r_len;
            end
            if (ar_fire) begin
                addr        <= addr + (ADDR_WIDTH'(blen) << ADDR_SHIFT);
                ar_rem      <= ar_rem - blen;
                outstanding <= OW'(blen);
            end
            if (r_fire) begin
                outstanding <= outstanding - OW'(1);
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                out_rem <= out_rem - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (r_fire) fifo_data[wr_ptr[IW-1:0]] <= src_r_data;
    end

`ifdef NASTI_STREAM_READER_RESP_CHECK_EN
    logic fifo_bad [DEPTH];
    logic err_q;

    always_ff @(posedge aclk) begin
        if (r_fire) fifo_bad[wr_ptr[IW-1:0]] <= (src_r_resp != 2'b00);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                           err_q <= 1'b0;
        else if (accept)                        err_q <= 1'b0;
        else if (r_fire && src_r_resp != 2'b00) err_q <= 1'b1;
    end

    assign head_bad = fifo_bad[rd_ptr[IW-1:0]];
    assign err      = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^src_r_resp;
    assign head_bad    = 1'b0;
    assign err         = 1'b0;
`endif

    a_aligned: assert property (@(posedge aclk) disable iff (!aresetn)
        accept |-> ((r_src & ADDR_MASK) == '0));
    a_r_last: assert property (@(posedge aclk) disable iff (!aresetn)
        r_fire |-> (src_r_last == (outstanding == OW'(1))));
endmodule

// File: tb/tb_nasti_stream_reader.sv
// Bench for nasti_stream_reader: memory slave model, stream sink with scoreboard, table of requests plus stall/reset sequences.
module tb_nasti_stream_reader;
    localparam int BW = 81;  // packed beat: {last, strb, keep, data}
`ifdef NASTI_STREAM_READER_RESP_CHECK_EN
    localparam bit RESP_EN = 1'b1;
`else
    localparam bit RESP_EN = 1'b0;
`endif

    logic        aclk, aresetn;
    logic        src_ar_valid, src_ar_ready, src_ar_lock;
    logic [3:0]  src_ar_id, src_ar_cache;
    logic [63:0] src_ar_addr;
    logic [7:0]  src_ar_len;
    logic [2:0]  src_ar_size, src_ar_prot;
    logic [1:0]  src_ar_burst;
    logic        src_r_valid, src_r_ready, src_r_last;
    logic [63:0] src_r_data;
    logic [1:0]  src_r_resp;
    logic        src_aw_valid, src_w_valid, src_b_ready;
    logic        dest_t_valid, dest_t_ready, dest_t_last;
    logic [63:0] dest_t_data;
    logic [7:0]  dest_t_keep, dest_t_strb;
    logic [63:0] r_src;
    logic [15:0] r_len;
    logic        r_valid, r_ready, err;
    logic [1:0]  dbg_req_state, dbg_ar_state;

    nasti_stream_reader dut (
        .aclk(aclk), .aresetn(aresetn),
        .src_ar_valid(src_ar_valid), .src_ar_ready(src_ar_ready), .src_ar_id(src_ar_id),
        .src_ar_addr(src_ar_addr), .src_ar_len(src_ar_len), .src_ar_size(src_ar_size),
        .src_ar_burst(src_ar_burst), .src_ar_lock(src_ar_lock), .src_ar_cache(src_ar_cache),
        .src_ar_prot(src_ar_prot), .src_r_valid(src_r_valid), .src_r_ready(src_r_ready),
        .src_r_data(src_r_data), .src_r_resp(src_r_resp), .src_r_last(src_r_last),
        .src_aw_valid(src_aw_valid), .src_w_valid(src_w_valid), .src_b_ready(src_b_ready),
        .dest_t_valid(dest_t_valid), .dest_t_ready(dest_t_ready), .dest_t_data(dest_t_data),
        .dest_t_keep(dest_t_keep), .dest_t_strb(dest_t_strb), .dest_t_last(dest_t_last),
        .r_src(r_src), .r_len(r_len), .r_valid(r_valid), .r_ready(r_ready), .err(err),
        .dbg_req_state(dbg_req_state), .dbg_ar_state(dbg_ar_state)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [71:0]   exp_ar_q[$];
    logic [63:0]   pend_addr[$];
    int            pend_len[$];
    int            r_idx = 0, r_beats = 0, ar_count = 0;
    int            t_mode = 0, hold_cnt = 0, err_beat = -1;
    bit            gap_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return 64'hA000 + ((a - 64'h1000) >> 3);
    endfunction

    function automatic logic [BW-1:0] pack_beat(input logic [63:0] d, input logic [7:0] k,
                                                input logic [7:0] s, input logic l);
        return {l, s, k, d};
    endfunction

    // memory slave + stream sink + scoreboard
    initial begin : bus_model
        logic        ar_wait, t_wait, r_fire;
        logic [71:0] held_ar;
        logic [64:0] held_t;
        logic [BW-1:0] got, e;
        ar_wait = 1'b0; t_wait = 1'b0;
        held_ar = '0; held_t = '0;
        src_ar_ready = 1'b0; src_r_valid = 1'b0; src_r_data = '0; src_r_resp = 2'b00;
        src_r_last = 1'b0; dest_t_ready = 1'b0;
        forever begin
            @(negedge aclk);
            r_fire = 1'b0;
            if (!aresetn) begin
                pend_addr.delete(); pend_len.delete();
                r_idx = 0; ar_wait = 1'b0; t_wait = 1'b0;
            end else begin
                if (ar_wait) check("ar_stable", {src_ar_valid, src_ar_addr, src_ar_len}, {1'b1, held_ar});
                if (t_wait) check("t_stable", {dest_t_valid, dest_t_data, dest_t_last}, {1'b1, held_t});
                ar_wait = src_ar_valid && !src_ar_ready;
                held_ar = {src_ar_addr, src_ar_len};
                t_wait  = dest_t_valid && !dest_t_ready;
                held_t  = {dest_t_data, dest_t_last};
                if (src_ar_valid && src_ar_ready) begin
                    ar_count++;
                    check("ar_fixed", {src_ar_id, src_ar_size, src_ar_burst, src_ar_lock, src_ar_cache, src_ar_prot},
                          {4'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0});
                    if (exp_ar_q.size() == 0) check("extra_ar", {src_ar_addr, src_ar_len}, 0);
                    else check("ar", {src_ar_addr, src_ar_len}, exp_ar_q.pop_front());
                    pend_addr.push_back(src_ar_addr);
                    pend_len.push_back(int'(src_ar_len) + 1);
                end
                if (src_r_valid && src_r_ready) begin
                    r_fire = 1'b1;
                    r_beats++;
                    if (src_r_last && pend_addr.size() > 0) begin
                        void'(pend_addr.pop_front());
                        void'(pend_len.pop_front());
                        r_idx = 0;
                    end else r_idx++;
                end
                if (dest_t_valid && dest_t_ready) begin
                    got = pack_beat(dest_t_data, dest_t_keep, dest_t_strb, dest_t_last);
                    if (exp_q.size() == 0) check("extra_beat", got, 0);
                    else begin
                        e = exp_q.pop_front();
                        if (e[71:64] == 8'h00) begin  // zero-length beat: data is don't-care
                            e[63:0] = '0;
                            got[63:0] = '0;
                        end
                        check("beat", got, e);
                    end
                end
            end
            @(posedge aclk); #1;
            if (!aresetn) begin
                src_r_valid = 1'b0; src_r_last = 1'b0; src_r_resp = 2'b00; src_ar_ready = 1'b0;
            end else begin
                if (!(src_r_valid && !r_fire)) begin
                    if (pend_addr.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                        src_r_valid = 1'b1;
                        src_r_data  = mem_word(pend_addr[0] + 64'(r_idx) * 8);
                        src_r_last  = (r_idx == pend_len[0] - 1);
                        src_r_resp  = (r_beats == err_beat) ? 2'b10 : 2'b00;
                    end else begin
                        src_r_valid = 1'b0; src_r_last = 1'b0; src_r_resp = 2'b00;
                    end
                end
                src_ar_ready = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            case (t_mode)
                0: dest_t_ready = 1'b1;
                1: dest_t_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (hold_cnt > 0) begin
                        dest_t_ready = 1'b0;
                        hold_cnt--;
                    end else dest_t_ready = 1'b1;
                end
            endcase
        end
    end

    // driver: build expectations and hand one request to the DUT
    task automatic issue(input logic [63:0] src, input int len, input int eb);
        logic [63:0] a;
        int rem, b, n;
        err_beat = eb; r_beats = 0; ar_count = 0;
        if (len == 0) exp_q.push_back(pack_beat(64'd0, 8'h00, 8'h00, 1'b1));
        for (int i = 0; i < len; i++)
            exp_q.push_back(pack_beat(mem_word(src + 64'(i) * 8), 8'hFF,
                                      (RESP_EN && i == eb) ? 8'h00 : 8'hFF, i == len - 1));
        a = src; rem = len;
        while (rem > 0) begin
            b = (rem > 8) ? 8 : rem;
            exp_ar_q.push_back({a, 8'(b - 1)});
            a += 64'(b) * 8;
            rem -= b;
        end
        @(posedge aclk); #1;
        r_src = src; r_len = 16'(len); r_valid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!r_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("req_accept", r_ready, 1'b1);
        @(posedge aclk); #1;
        r_valid = 1'b0;
        @(negedge aclk);
        check("r_ready_busy", r_ready, 1'b0);
    endtask

    task automatic finish_vector(input int n_ar, input logic exp_err);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && r_ready) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check("done", {exp_q.size() == 0, r_ready}, 2'b11);
        check("ar_count", ar_count, n_ar);
        check("ar_all_seen", exp_ar_q.size(), 0);
        check("err", err, exp_err);
        exp_q.delete();
        exp_ar_q.delete();
    endtask

    typedef struct {
        logic [63:0] src;
        int          len;
        int          mode;
        bit          gaps;
        int          eb;
        int          n_ar;
        logic        exp_err;
    } vec_t;

    initial begin : main
        vec_t vecs[6];
        int n;
        vecs[0] = '{64'h1000, 8,  0, 1'b0, -1, 1, 1'b0};
        vecs[1] = '{64'h1000, 20, 0, 1'b0, -1, 3, 1'b0};
        vecs[2] = '{64'h1000, 0,  0, 1'b0, -1, 0, 1'b0};
        vecs[3] = '{64'h2000, 13, 1, 1'b1, -1, 2, 1'b0};
        vecs[4] = '{64'h3000, 8,  0, 1'b0, 2,  1, RESP_EN};
        vecs[5] = '{64'h1100, 5,  1, 1'b0, -1, 1, 1'b0};

        aresetn = 1'b0; r_src = '0; r_len = '0; r_valid = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset_outputs",
              {r_ready, src_ar_valid, src_r_ready, dest_t_valid, dest_t_last, err,
               src_aw_valid, src_w_valid, src_b_ready, dbg_req_state, dbg_ar_state},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0});
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < 6; i++) begin
            t_mode = vecs[i].mode;
            gap_en = vecs[i].gaps;
            issue(vecs[i].src, vecs[i].len, vecs[i].eb);
            finish_vector(vecs[i].n_ar, vecs[i].exp_err);
        end

        // consumer stalled: the buffer fills to two bursts and AR/R stop
        gap_en = 1'b0; hold_cnt = 100000; t_mode = 2;
        issue(64'h1000, 32, -1);
        repeat (40) @(negedge aclk);
        check("stall_r_beats", r_beats, 16);
        check("stall_idle", {src_ar_valid, src_r_ready, dest_t_valid}, 3'b001);
        hold_cnt = 0;
        finish_vector(4, 1'b0);

        // reset in the middle of a burst, then a clean request
        t_mode = 0;
        issue(64'h1000, 16, -1);
        n = 0;
        while (r_beats < 5 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("reached_beat5", r_beats >= 5, 1'b1);
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        check("midreset_outputs",
              {r_ready, src_ar_valid, src_r_ready, dest_t_valid, dest_t_last, err},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        exp_q.delete();
        exp_ar_q.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        issue(64'h1000, 4, -1);
        finish_vector(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nasti_stream_reader.md
Name: nasti_stream_reader

Overview:
- Memory-to-stream data mover; the read-direction counterpart of the team's stream-to-NASTI writer.
- On a request (start address, beat count), it issues INCR read bursts on a NASTI master port and buffers the returned R beats.
- It emits the buffered beats as a NASTI-stream packet, with t_last on the final beat.
- Sits between DMA/control logic and stream consumers (e.g. Ethernet TX, SD card write path).

Parameters:
- ADDR_WIDTH, 64, width of request and AR address.
- DATA_WIDTH, 64, NASTI and stream data width in bits (power of 2, at least 8).
- MAX_BURST_LENGTH, 8, maximum beats per AR burst (power of 2, at most 256).
- LEN_WIDTH, 16, width of the beat-count request field.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous, active-low reset.
- src  nasti_channel  -  NASTI master. Only AR and R are used. aw_valid, w_valid are driven 0; b_ready is driven 1.
- dest  nasti_stream_channel.master  -  output stream: t_valid, t_ready, t_data, t_keep, t_strb, t_last.
- r_src  input  ADDR_WIDTH  request start address; must be DATA_WIDTH/8-aligned.
- r_len  input  LEN_WIDTH  request length in beats; 0 is legal.
- r_valid  input  1  request valid.
- r_ready  output  1  high when idle and able to accept a request.
- err  output  1  sticky read-error flag (see Optional Feature).

Behaviour:
- Reset values: r_ready=1, ar_valid=0, r_ready on the NASTI port (src.r_ready)=0, t_valid=0, t_last=0, err=0. FIFO pointers, outstanding count, remaining counters and state are all 0 / IDLE.
- Reset mid-operation aborts everything; no further AR is issued; buffered data is discarded.
- Request accept: r_valid & r_ready. On accept:
  - latch addr = r_src with the low $clog2(DATA_WIDTH/8) bits forced to 0;
  - ar_rem = r_len, out_rem = r_len;
  - r_ready falls the next cycle;
  - simulation assertion that r_src is aligned.
- Zero-length request: emit one beat with t_keep=0, t_strb=0, t_last=1, t_data don't-care. No AR is issued. r_ready returns high the cycle after that beat fires.
- Constant AR fields: ar_id=0, ar_size=$clog2(DATA_WIDTH/8), ar_burst=INCR, ar_cache=0, ar_prot=0, ar_lock=0.
- Buffer: circular FIFO, depth 2*MAX_BURST_LENGTH, pointers one bit wider than the index for full/empty detection.
- AR state machine, one burst outstanding at most:
  - AR_IDLE -> AR_ADDR when ar_rem != 0 and (free slots - 0) >= blen, where blen = min(ar_rem, MAX_BURST_LENGTH). Drive ar_valid=1, ar_addr=addr, ar_len=blen-1.
  - AR_ADDR: hold ar_addr/ar_len stable until ar_ready. On fire: addr += blen << ADDR_SHIFT, ar_rem -= blen, outstanding = blen, then -> AR_DATA.
  - AR_DATA: src.r_ready=1. Each r fire pushes r_data and decrements outstanding. On r_last -> AR_IDLE. Assert r_last coincides with outstanding==1.
  - Free-slot check guarantees no overflow; src.r_ready may therefore stay high in AR_DATA.
- Stream output:
  - t_valid = FIFO not empty; t_data = FIFO head; t_keep and t_strb all ones; t_last = (out_rem == 1).
  - On t fire: pop and decrement out_rem. When out_rem reaches 0, return to idle and set r_ready=1 the next cycle.
  - t_valid/t_data stay stable while t_ready is low (AXI-Stream rule).
- Simultaneous push and pop in the same cycle: occupancy unchanged. A FIFO pass-through latency of 1 cycle (R fire -> t_valid) is acceptable.
- Full-bandwidth requirement: once the first burst returns, the second AR may be issued while the first burst drains, provided free slots >= blen.
- Requests are not split at 4 KiB boundaries; the caller guarantees this.

Optional Feature:
- Macro: NASTI_STREAM_READER_RESP_CHECK_EN.
- Defined:
  - any R beat with r_resp != OKAY sets err=1, which stays set until the next request accept clears it;
  - the data is still forwarded;
  - t_strb of the affected beat is driven all zeros to mark it.
- Undefined: r_resp is ignored, err is tied 0, and t_strb is always all ones.

Test Plan:
- r_src=0x1000, r_len=8, memory word i = 0xA000+i, t_ready=1 -> one AR (addr 0x1000, len 7); 8 stream beats 0xA000..0xA007; t_last only on beat 8; r_ready high again afterwards.
- r_len=20, MAX_BURST_LENGTH=8 -> AR sequence (0x1000,len7), (0x1040,len7), (0x1080,len3); 20 beats in order; t_last on beat 20.
- r_len=0 -> no AR; a single beat with t_keep=0, t_last=1; r_ready returns.
- r_len=32 with t_ready held low for 40 cycles, then high -> at most 16 beats accepted on R and src.r_ready/ar_valid stall. After release, all 32 beats arrive in order, none lost or duplicated.
- Randomized ar_ready/r_valid/t_ready gaps, r_len=13 -> output matches memory order; AR fields stable while ar_valid=1 and ar_ready=0.
- aresetn asserted mid-burst (beat 5 of 16) -> all outputs at reset values; a new request with r_len=4 then completes normally. With RESP_CHECK_EN, beat 3 returning SLVERR sets err=1 and t_strb=0 on that beat.
